uart_rx_param: RTL and testbench
================================

// Module: uart_rx_param
// PURPOSE
//   Parametrised UART receiver. Runs from one system clock with an internal baud divider,
//   mid-bit sampling and a 2-flop input synchroniser.
//   Supports 5..9 data bits, optional odd/even parity and 1 or 2 stop bits.
//   Delivers each frame on a valid/ready output port with parity, framing and overrun status.
//   Sits between the serial pin and a byte FIFO or register file.
// PARAMETERS
//   DATA_BITS    8   data bits per frame, LSB first, legal 5..9
//   PARITY_EN    1   1 = parity bit follows data, 0 = no parity bit
//   PARITY_ODD   0   0 = even parity, 1 = odd parity (ignored when PARITY_EN=0)
//   STOP_BITS    1   stop bits checked, legal 1 or 2
//   CLKS_PER_BIT 16  clk cycles per bit period, even, >= 4
// PORTS
//   clk         in   1          system clock, all logic on rising edge
//   reset       in   1          asynchronous, active-low reset
//   d_in        in   1          serial line, idle high, asynchronous to clk
//   rx_data     out  DATA_BITS  received data word
//   rx_valid    out  1          rx_data and status flags are valid
//   rx_ready    in   1          consumer accepts the word when rx_valid & rx_ready
//   parity_err  out  1          parity mismatch on the held word (0 when PARITY_EN=0)
//   frame_err   out  1          a stop bit sampled 0 on the held word
//   overrun     out  1          1-cycle pulse: a completed frame was dropped
//   busy        out  1          high in every state except IDLE
// BEHAVIOUR
//   Reset
//     Synchroniser flops = 1. State = IDLE. All counters = 0.
//     rx_data = 0; rx_valid, parity_err, frame_err, overrun, busy = 0.
//     Reset is honoured in any state; a partial frame is discarded and never delivered.
//   Synchroniser
//     d_s = 2-flop synchronised d_in. The FSM uses only d_s.
//   Baud counter
//     cnt counts down; the sample strobe fires when cnt == 0.
//     On each strobe cnt reloads to CLKS_PER_BIT-1.
//   FSM
//     IDLE:   d_s == 0 -> START, cnt = CLKS_PER_BIT/2-1, busy = 1.
//     START:  strobe (mid start bit).
//               d_s == 1 -> IDLE (glitch; no flags, no output).
//               d_s == 0 -> DATA, bit_idx = 0.
//     DATA:   each strobe shifts d_s in LSB-first; bit_idx++.
//               After bit DATA_BITS-1 -> PARITY if PARITY_EN, else STOP.
//     PARITY: strobe samples p.
//               p_err = (^data ^ p) != PARITY_ODD.
//               Then -> STOP with stop_idx = 0.
//     STOP:   each strobe: if d_s == 0, set f_err.
//               After STOP_BITS samples: commit, then -> IDLE.
//               Returning to IDLE at mid stop bit is intended; IDLE waits for the next low.
//   Commit (registered; rx_valid rises the cycle after the last stop-bit strobe)
//     Slot free (rx_valid == 0, or rx_valid & rx_ready in the same cycle):
//       rx_data = data, parity_err = p_err, frame_err = f_err, rx_valid = 1.
//     Slot held (rx_valid & !rx_ready): new frame dropped, held word and flags unchanged,
//       overrun pulses high for 1 cycle.
//   Output handshake
//     rx_valid & rx_ready with no commit in the same cycle -> rx_valid = 0.
//     parity_err and frame_err clear together with rx_valid.
//     rx_data holds its last value.
//     Words with errors are still delivered; the flags qualify them.
//   Timing
//     Sample k (0 = start bit) falls CLKS_PER_BIT/2 + k*CLKS_PER_BIT cycles after d_s first reads 0.
//     Total pin-to-rx_valid latency is 2 synchroniser cycles + sample time of the last stop bit + 1.
//   Width rules
//     bit_idx is sized clog2(DATA_BITS+1).
//     cnt is sized clog2(CLKS_PER_BIT).
//     No wrap beyond the stated terminal counts.
// TESTING (CLKS_PER_BIT=16, DATA_BITS=8, even parity, 1 stop unless noted)
//   1 Frame 0xA5, parity 0, stop 1 -> rx_data=0xA5, rx_valid=1, parity_err=0, frame_err=0,
//     rx_valid rises exactly 1 cycle after the stop-bit strobe.
//   2 Frame 0x3C with parity bit 1 -> rx_data=0x3C, parity_err=1, frame_err=0.
//   3 Frame 0x81 with stop bit 0 -> rx_data=0x81, frame_err=1.
//     The next good frame 0x7E is received cleanly.
//   4 d_in low for 4 clk then high -> no rx_valid, busy falls after the start strobe, no flags.
//   5 rx_ready=0; frames 0x11 then 0x22 -> rx_data stays 0x11, overrun pulses 1 cycle at the
//     second commit. Then rx_ready=1 for 1 cycle -> rx_valid=0.
//   6 reset low mid-DATA of 0x55 -> all outputs 0 immediately; after release, frame 0x5A -> rx_data=0x5A.
//     Repeat scenario 1 with PARITY_EN=0, STOP_BITS=2, DATA_BITS=7 (frame 0x2A) -> rx_data=0x2A.

Source files
------------

// File: rtl/uart_rx_param.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_param
// Description : Parametrised UART receiver. A single system clock drives an
//               internal baud divider with mid-bit sampling. The serial input
//               passes through a 2-flop synchroniser. The receiver handles
//               5..9 data bits (LSB first), optional odd/even parity and 1 or 2
//               stop bits. Each frame is delivered on a valid/ready port
//               together with parity, framing and overrun status.
// Ports       : clk        - system clock, rising edge
//               reset      - asynchronous, active-low reset
//               d_in       - serial line, idle high, asynchronous to clk
//               rx_data    - received data word (holds its last value)
//               rx_valid   - rx_data and the status flags are valid
//               rx_ready   - consumer accepts the word when rx_valid & rx_ready
//               parity_err - parity mismatch on the held word
//               frame_err  - a stop bit was sampled low on the held word
//               overrun    - 1-cycle pulse: a completed frame was dropped
//               busy       - receiver is not in IDLE
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_param #(
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 1,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 d_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS + 1);

  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
  localparam logic             STOP_LAST = (STOP_BITS == 2);
  localparam logic             PAR_ODD   = (PARITY_ODD != 0);
  localparam logic             PAR_EN    = (PARITY_EN != 0);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  // --------------------------------------------------------------------------
  // Input synchroniser; flops reset to the idle (high) line level so that
  // leaving reset never looks like a start bit.
  // --------------------------------------------------------------------------
  logic sync1;
  logic d_s;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b1;
      d_s   <= 1'b1;
    end else begin
      sync1 <= d_in;
      d_s   <= sync1;
    end
  end

  // --------------------------------------------------------------------------
  // Frame FSM and datapath registers
  // --------------------------------------------------------------------------
  state_t               state,    state_n;
  logic [CNT_W-1:0]     cnt,      cnt_n;
  logic [IDX_W-1:0]     bit_idx,  bit_idx_n;
  logic                 stop_idx, stop_idx_n;
  logic [DATA_BITS-1:0] shreg,    shreg_n;
  logic                 p_err,    p_err_n;
  logic                 f_err,    f_err_n;
  logic                 commit;
  logic                 strobe;

  assign strobe = (cnt == '0);
  assign busy   = (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      shreg    <= '0;
      p_err    <= 1'b0;
      f_err    <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      bit_idx  <= bit_idx_n;
      stop_idx <= stop_idx_n;
      shreg    <= shreg_n;
      p_err    <= p_err_n;
      f_err    <= f_err_n;
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    bit_idx_n  = bit_idx;
    stop_idx_n = stop_idx;
    shreg_n    = shreg;
    p_err_n    = p_err;
    f_err_n    = f_err;
    commit     = 1'b0;

    // Free-running divider while a frame is in progress; reload on strobe.
    if (state != IDLE) begin
      cnt_n = strobe ? CNT_FULL : (cnt - CNT_ONE);
    end

    case (state)
      IDLE: begin
        if (!d_s) begin
          // Half-bit preload puts every following strobe at mid-bit.
          state_n    = START;
          cnt_n      = CNT_HALF;
          bit_idx_n  = '0;
          stop_idx_n = 1'b0;
          p_err_n    = 1'b0;
          f_err_n    = 1'b0;
        end
      end
      START: begin
        if (strobe) begin
          if (d_s) begin
            // Line went back high before mid start bit: treat as a glitch.
            state_n = IDLE;
            cnt_n   = '0;
          end else begin
            state_n   = DATA;
            bit_idx_n = '0;
          end
        end
      end
      DATA: begin
        if (strobe) begin
          shreg_n   = {d_s, shreg[DATA_BITS-1:1]};
          bit_idx_n = bit_idx + IDX_ONE;
          if (bit_idx == IDX_LAST) begin
            state_n    = PAR_EN ? PARITY : STOP;
            stop_idx_n = 1'b0;
          end
        end
      end
      PARITY: begin
        if (strobe) begin
          p_err_n    = (((^shreg) ^ d_s) != PAR_ODD);
          state_n    = STOP;
          stop_idx_n = 1'b0;
        end
      end
      STOP: begin
        if (strobe) begin
          f_err_n = f_err | ~d_s;
          if (stop_idx == STOP_LAST) begin
            // Back to IDLE at mid stop bit; IDLE simply waits for the next low.
            commit  = 1'b1;
            state_n = IDLE;
            cnt_n   = '0;
          end else begin
            stop_idx_n = 1'b1;
          end
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Output slot: a commit always wins over a same-cycle handshake, so a slot
  // being consumed in the commit cycle is refilled instead of emptied.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (commit) begin
        if (!rx_valid || rx_ready) begin
          rx_data    <= shreg;
          parity_err <= p_err_n;
          frame_err  <= f_err_n;
          rx_valid   <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid   <= 1'b0;
        parity_err <= 1'b0;
        frame_err  <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_param
// Description : Directed testbench for uart_rx_param. One instance uses the
//               default 8E1 configuration, a second uses 7N2. Serial frames
//               are driven on the falling clock edge, one bit per 16 clocks,
//               and outputs are sampled on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_param;

  logic       clk;
  logic       reset;
  logic       d_in;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       parity_err;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  logic       d_in2;
  logic [6:0] rx_data2;
  logic       rx_valid2;
  logic       rx_ready2;
  logic       parity_err2;
  logic       frame_err2;
  logic       overrun2;
  logic       busy2;

  int total;
  int bad;
  int rise_v;
  int rise_o;
  int ocnt;

  uart_rx_param u_dut (
    .clk        (clk),
    .reset      (reset),
    .d_in       (d_in),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .busy       (busy)
  );

  uart_rx_param #(
    .DATA_BITS    (7),
    .PARITY_EN    (0),
    .PARITY_ODD   (0),
    .STOP_BITS    (2),
    .CLKS_PER_BIT (16)
  ) u_dut2 (
    .clk        (clk),
    .reset      (reset),
    .d_in       (d_in2),
    .rx_data    (rx_data2),
    .rx_valid   (rx_valid2),
    .rx_ready   (rx_ready2),
    .parity_err (parity_err2),
    .frame_err  (frame_err2),
    .overrun    (overrun2),
    .busy       (busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // 8E1 line levels: [0] start, [8:1] data LSB first, [9] parity, [10] stop
  function automatic logic [15:0] f8(input logic [7:0] d, input logic p, input logic s);
    logic [15:0] r;
    r      = 16'hFFFF;
    r[0]   = 1'b0;
    r[8:1] = d;
    r[9]   = p;
    r[10]  = s;
    return r;
  endfunction

  // 7N2 line levels: [0] start, [7:1] data, [8] stop1, [9] stop2
  function automatic logic [15:0] f7(input logic [6:0] d, input logic s2);
    logic [15:0] r;
    r      = 16'hFFFF;
    r[0]   = 1'b0;
    r[7:1] = d;
    r[8]   = 1'b1;
    r[9]   = s2;
    return r;
  endfunction

  // Drives nbits bit periods; n counts falling edges from the start-bit edge.
  // Records the first edge where valid/overrun is seen high.
  task automatic send(input bit which, input logic [15:0] lv, input int nbits);
    rise_v = -1;
    rise_o = -1;
    ocnt   = 0;
    for (int n = 0; n < nbits * 16; n++) begin
      @(negedge clk);
      if (!which) begin
        if (rx_valid && rise_v < 0) rise_v = n;
        if (overrun) begin
          ocnt++;
          if (rise_o < 0) rise_o = n;
        end
        d_in = lv[n / 16];
      end else begin
        if (rx_valid2 && rise_v < 0) rise_v = n;
        d_in2 = lv[n / 16];
      end
    end
  endtask

  task automatic idle(input int k);
    @(negedge clk);
    d_in  = 1'b1;
    d_in2 = 1'b1;
    repeat (k) @(negedge clk);
  endtask

  task automatic consume();
    @(negedge clk);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    reset     = 1'b0;
    d_in      = 1'b1;
    d_in2     = 1'b1;
    rx_ready  = 1'b0;
    rx_ready2 = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_data",   32'(rx_data),    32'h0);
    check("rst_valid",  32'(rx_valid),   32'h0);
    check("rst_perr",   32'(parity_err), 32'h0);
    check("rst_ferr",   32'(frame_err),  32'h0);
    check("rst_ovr",    32'(overrun),    32'h0);
    check("rst_busy",   32'(busy),       32'h0);
    reset = 1'b1;
    repeat (5) @(negedge clk);

    // 1: clean frame 0xA5 (4 ones -> even parity 0); latency 2+8+160+1
    send(0, f8(8'hA5, 1'b0, 1'b1), 11);
    check("t1_rise",  32'(rise_v),     32'd171);
    check("t1_data",  32'(rx_data),    32'hA5);
    check("t1_valid", 32'(rx_valid),   32'h1);
    check("t1_perr",  32'(parity_err), 32'h0);
    check("t1_ferr",  32'(frame_err),  32'h0);
    idle(4);
    check("t1_busy",  32'(busy),       32'h0);
    consume();
    check("t1_taken", 32'(rx_valid),   32'h0);
    check("t1_hold",  32'(rx_data),    32'hA5);

    // 2: 0x3C has 4 ones; parity bit 1 is wrong for even parity
    idle(10);
    send(0, f8(8'h3C, 1'b1, 1'b1), 11);
    check("t2_data",  32'(rx_data),    32'h3C);
    check("t2_perr",  32'(parity_err), 32'h1);
    check("t2_ferr",  32'(frame_err),  32'h0);
    consume();
    check("t2_pclr",  32'(parity_err), 32'h0);

    // 3: 0x81 with stop bit low, then a clean 0x7E
    idle(10);
    send(0, f8(8'h81, 1'b0, 1'b0), 11);
    check("t3_data",  32'(rx_data),    32'h81);
    check("t3_ferr",  32'(frame_err),  32'h1);
    check("t3_perr",  32'(parity_err), 32'h0);
    idle(40);
    consume();
    check("t3_fclr",  32'(frame_err),  32'h0);
    idle(10);
    send(0, f8(8'h7E, 1'b0, 1'b1), 11);
    check("t3b_rise", 32'(rise_v),     32'd171);
    check("t3b_data", 32'(rx_data),    32'h7E);
    check("t3b_ferr", 32'(frame_err),  32'h0);
    check("t3b_perr", 32'(parity_err), 32'h0);
    consume();

    // 4: 4-clock low glitch is rejected at the start strobe
    idle(10);
    @(negedge clk);
    d_in = 1'b0;
    repeat (4) @(negedge clk);
    d_in = 1'b1;
    @(negedge clk);
    check("t4_busy_hi", 32'(busy),       32'h1);
    repeat (7) @(negedge clk);
    check("t4_busy_lo", 32'(busy),       32'h0);
    repeat (30) @(negedge clk);
    check("t4_valid",   32'(rx_valid),   32'h0);
    check("t4_perr",    32'(parity_err), 32'h0);
    check("t4_ferr",    32'(frame_err),  32'h0);

    // 5: overrun with consumer stalled
    send(0, f8(8'h11, 1'b0, 1'b1), 11);
    check("t5_rise1", 32'(rise_v),   32'd171);
    check("t5_data1", 32'(rx_data),  32'h11);
    idle(20);
    send(0, f8(8'h22, 1'b0, 1'b1), 11);
    check("t5_orise", 32'(rise_o),   32'd171);
    check("t5_ocnt",  32'(ocnt),     32'd1);
    check("t5_data2", 32'(rx_data),  32'h11);
    check("t5_valid", 32'(rx_valid), 32'h1);
    check("t5_olow",  32'(overrun),  32'h0);
    consume();
    check("t5_taken", 32'(rx_valid), 32'h0);

    // 6: reset in the middle of the data bits of 0x55
    idle(10);
    send(0, f8(8'h55, 1'b0, 1'b1), 5);
    @(negedge clk);
    check("t6_busy_pre", 32'(busy), 32'h1);
    reset = 1'b0;
    #1;
    check("t6_data",  32'(rx_data),    32'h0);
    check("t6_valid", 32'(rx_valid),   32'h0);
    check("t6_busy",  32'(busy),       32'h0);
    check("t6_perr",  32'(parity_err), 32'h0);
    check("t6_ferr",  32'(frame_err),  32'h0);
    d_in = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    idle(40);
    check("t6_nodeliv", 32'(rx_valid), 32'h0);
    send(0, f8(8'h5A, 1'b0, 1'b1), 11);
    check("t6_rise",  32'(rise_v),     32'd171);
    check("t6_data2", 32'(rx_data),    32'h5A);
    check("t6_perr2", 32'(parity_err), 32'h0);
    consume();

    // 7: 7N2 instance; latency 2+8+144+1
    idle(10);
    send(1, f7(7'h2A, 1'b1), 10);
    check("t7_rise",  32'(rise_v),      32'd155);
    check("t7_data",  32'(rx_data2),    32'h2A);
    check("t7_valid", 32'(rx_valid2),   32'h1);
    check("t7_perr",  32'(parity_err2), 32'h0);
    check("t7_ferr",  32'(frame_err2),  32'h0);
    @(negedge clk);
    rx_ready2 = 1'b1;
    @(negedge clk);
    rx_ready2 = 1'b0;
    check("t7_taken", 32'(rx_valid2),   32'h0);
    // second stop bit low must flag a framing error
    idle(10);
    send(1, f7(7'h55, 1'b0), 10);
    check("t7b_rise", 32'(rise_v),      32'd155);
    check("t7b_data", 32'(rx_data2),    32'h55);
    check("t7b_ferr", 32'(frame_err2),  32'h1);
    idle(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
